// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the multicycle control unit and seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             ready;
  logic             div_zero;
  logic             busy;

  modport master (
    output start, a, b,
    input  hi, lo, ready, div_zero, busy
  );

  modport slave (
    input  start, a, b,
    output hi, lo, ready, div_zero, busy
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative signed divider for MIPS DIV: restoring division on magnitudes, one quotient bit
// per cycle, sign fix-up in a final step. Quotient goes to lo, remainder to hi.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH:0]   divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             negQuot_q;
  logic             negRem_q;
  logic             ready_q;
  logic             divZero_q;
  logic             busy_q;

  logic [WIDTH-1:0] aAbs_d;
  logic [WIDTH-1:0] bAbs_d;
  logic [WIDTH:0]   remShift_d;
  logic [WIDTH:0]   diff_d;
  logic             remGeq_d;
  logic [WIDTH-1:0] remNext_d;
  logic [WIDTH-1:0] quotNext_d;

  // The dividend lives in quot_q and is shifted out MSB-first as quotient bits shift in.
  // Borrow out of the WIDTH+1 bit subtract doubles as the remainder >= divisor compare.
  always_comb begin
    aAbs_d     = bus.a[WIDTH-1] ? -bus.a : bus.a;
    bAbs_d     = bus.b[WIDTH-1] ? -bus.b : bus.b;
    remShift_d = {rem_q, quot_q[WIDTH-1]};
    diff_d     = remShift_d - divisor_q;
    remGeq_d   = ~diff_d[WIDTH];
    remNext_d  = remGeq_d ? diff_d[WIDTH-1:0] : remShift_d[WIDTH-1:0];
    quotNext_d = {quot_q[WIDTH-2:0], remGeq_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      ready_q   <= 1'b0;
      divZero_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q   <= 1'b0;
      divZero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.b == '0) begin
              divZero_q <= 1'b1;
              ready_q   <= 1'b1;
            end else begin
              divisor_q <= {1'b0, bAbs_d};
              quot_q    <= aAbs_d;
              rem_q     <= '0;
              negQuot_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              negRem_q  <= bus.a[WIDTH-1];
              count_q   <= CW'(WIDTH);
              busy_q    <= 1'b1;
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          rem_q   <= remNext_d;
          quot_q  <= quotNext_d;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          lo_q    <= negQuot_q ? -quot_q : quot_q;
          hi_q    <= negRem_q ? -rem_q : rem_q;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.ready    = ready_q;
  assign bus.div_zero = divZero_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: signed results, latency, back-to-back, divide-by-zero,
// operand isolation, ignored start while busy, and reset mid-division.
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   cycles;
  int   readySeen;

  seq_divider_if #(.WIDTH(32)) divBus ();

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (divBus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; presents operands with start for one edge, returns just after that edge.
  task automatic applyStimulus(input logic [31:0] aVal, input logic [31:0] bVal);
    divBus.start = 1'b1;
    divBus.a     = aVal;
    divBus.b     = bVal;
    @(negedge clk);
    divBus.start = 1'b0;
  endtask

  task automatic waitReady(input int maxCycles, output int seen);
    seen = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(negedge clk);
      if (divBus.ready === 1'b1) begin
        seen = i;
        break;
      end
    end
  endtask

  task automatic runDivision(input string tag, input logic [31:0] aVal, input logic [31:0] bVal,
                             input logic [31:0] expLo, input logic [31:0] expHi);
    int seen;
    applyStimulus(aVal, bVal);
    checkOutput({tag, "_busy_e0"}, 32'(divBus.busy), 32'd1);
    waitReady(40, seen);
    checkOutput({tag, "_latency"}, 32'(seen), 32'd33);
    checkOutput({tag, "_lo"}, divBus.lo, expLo);
    checkOutput({tag, "_hi"}, divBus.hi, expHi);
    checkOutput({tag, "_busy_done"}, 32'(divBus.busy), 32'd0);
    checkOutput({tag, "_dz_done"}, 32'(divBus.div_zero), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    divBus.start = 1'b0;
    divBus.a     = '0;
    divBus.b     = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_hi", divBus.hi, 32'd0);
    checkOutput("rst_lo", divBus.lo, 32'd0);
    checkOutput("rst_ready", 32'(divBus.ready), 32'd0);
    checkOutput("rst_dz", 32'(divBus.div_zero), 32'd0);
    checkOutput("rst_busy", 32'(divBus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    runDivision("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
    @(negedge clk);
    checkOutput("d100_7_ready_drop", 32'(divBus.ready), 32'd0);

    runDivision("dm7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    @(negedge clk);

    // Second start lands in the ready cycle of the first; 33 + 1 cycles between ready pulses.
    runDivision("d7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    runDivision("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    @(negedge clk);

    runDivision("preload", 32'd100, 32'd7, 32'd14, 32'd2);
    @(negedge clk);
    applyStimulus(32'd5, 32'd0);
    checkOutput("dz_flag", 32'(divBus.div_zero), 32'd1);
    checkOutput("dz_ready", 32'(divBus.ready), 32'd1);
    checkOutput("dz_busy", 32'(divBus.busy), 32'd0);
    checkOutput("dz_hi", divBus.hi, 32'd2);
    checkOutput("dz_lo", divBus.lo, 32'd14);
    @(negedge clk);
    checkOutput("dz_flag_drop", 32'(divBus.div_zero), 32'd0);
    checkOutput("dz_ready_drop", 32'(divBus.ready), 32'd0);
    checkOutput("dz_busy_after", 32'(divBus.busy), 32'd0);

    // Operands change at E5 and start pulses at E10; neither may disturb the running division.
    applyStimulus(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    divBus.a = 32'd1;
    divBus.b = 32'd1;
    repeat (5) @(negedge clk);
    divBus.start = 1'b1;
    @(negedge clk);
    divBus.start = 1'b0;
    checkOutput("iso_busy_e10", 32'(divBus.busy), 32'd1);
    waitReady(40, cycles);
    checkOutput("iso_latency", 32'(cycles), 32'd23);
    checkOutput("iso_lo", divBus.lo, 32'd14);
    checkOutput("iso_hi", divBus.hi, 32'd2);
    @(negedge clk);
    checkOutput("iso_busy_after", 32'(divBus.busy), 32'd0);
    checkOutput("iso_ready_after", 32'(divBus.ready), 32'd0);

    // Reset at E10 aborts the division and clears the results.
    applyStimulus(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 32'(divBus.busy), 32'd0);
    checkOutput("abort_hi", divBus.hi, 32'd0);
    checkOutput("abort_lo", divBus.lo, 32'd0);
    readySeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (divBus.ready === 1'b1) readySeen++;
      @(negedge clk);
    end
    checkOutput("abort_no_ready", 32'(readySeen), 32'd0);
    runDivision("d9_3", 32'd9, 32'd3, 32'd3, 32'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative signed 32-bit divider for the multicycle MIPS datapath. It implements DIV.
- Quotient goes to `lo` and remainder to `hi`; the control unit copies them into the HI/LO registers.
- It accepts operands from the A/B registers on a `start` pulse and computes one quotient bit per cycle.
- It reports completion with a one-cycle `ready` pulse, or flags divide-by-zero with `div_zero` so the control unit can raise an exception.

Parameters:
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only while idle.
- a  input  WIDTH  dividend, two's complement.
- b  input  WIDTH  divisor, two's complement.
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- ready  output  1  one-cycle pulse: hi/lo were updated at the same edge.
- div_zero  output  1  one-cycle pulse: b was zero; hi/lo are unchanged.
- busy  output  1  high while a division is in progress.

Behaviour:
- Reset (synchronous): at any clock edge with reset=1, including mid-operation:
  - state goes to IDLE;
  - hi=0, lo=0, ready=0, div_zero=0, busy=0;
  - the iteration counter and internal working registers are cleared;
  - the partial result is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start=1 and b!=0 (edge E0):
    - latch |a|, |b|, sign(a), and sign(a)^sign(b);
    - clear the partial remainder and set the counter to WIDTH;
    - go to RUN and set busy=1.
  - On an edge with start=1 and b==0:
    - set div_zero=1 and ready=1 for exactly one cycle;
    - hi/lo keep their previous values;
    - stay in IDLE.
- RUN (edges E1..E32): unsigned restoring division, one step per edge.
  - Shift {remainder, quotient} left by 1, bringing in the next dividend MSB.
  - If remainder >= |b|: subtract |b| and set the quotient LSB to 1; otherwise set it to 0.
  - Decrement the counter; when it reaches 0 after the 32nd step, go to FIX.
- FIX (edge E33):
  - lo = negate(quotient) if the signs differ, else quotient.
  - hi = negate(remainder) if a was negative, else remainder; the remainder sign follows the dividend.
  - ready=1, busy=0, go to IDLE.
- Latency: ready is high during the cycle between E33 and E34, i.e. 33 cycles after the start-sampling edge. ready and div_zero drop at the next edge.
- Operand isolation: a and b are captured at E0; later changes on a/b have no effect on the result.
- start while busy (RUN or FIX) is ignored; no queuing.
- start=1 in the cycle where ready=1 (state IDLE) is accepted, allowing back-to-back divisions.
- Overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No flag is raised, matching MIPS DIV.
- |0x80000000| is handled as unsigned 0x80000000; the working registers are WIDTH+1 bits wide for the compare/subtract.
- ready and div_zero are never high together except on divide-by-zero, where both pulse.
- hi/lo change only at a FIX edge or at reset.

Test Plan:
- a=100, b=7, start for 1 cycle → busy=1 from E0; ready pulse after E33 with lo=14, hi=2; busy=0 in the same cycle.
- a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- a=7, b=0xFFFFFFFE (-2), then a=0x80000000, b=0xFFFFFFFF back-to-back (second start in the ready cycle):
  - first result: lo=0xFFFFFFFD, hi=1;
  - second result: lo=0x80000000, hi=0, with ready exactly 34 cycles after the first ready.
- Preload hi/lo via 100/7, then a=5, b=0 → div_zero=1 and ready=1 for one cycle at E0+1; hi=2 and lo=14 unchanged; busy stays 0.
- Start 100/7, then change a/b to 1/1 at E5, and pulse start again at E10 → the second start is ignored; the result is lo=14, hi=2 at the usual cycle.
- Start 100/7, assert reset at E10 → next cycle: busy=0, hi=0, lo=0, no ready pulse ever appears; a new start of 9/3 then gives lo=3, hi=0 after 33 cycles.
